// File: rtl/gpu_cmd_master.sv
// gpu_cmd_master: buffers draw commands in a small FIFO and replays each one
// as status polls and register writes on the GPU's memory-mapped port.
module gpu_cmd_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] GPU_BASE   = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_rect,
  input  logic [15:0] cmd_point,
  input  logic [23:0] cmd_color,
  output logic        gpu_enable,
  output logic [31:0] gpu_address,
  output logic [31:0] gpu_data,
  input  logic [31:0] gpu_rdata,
  output logic        busy,
  output logic [15:0] cmd_count,
  output logic        err_op,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [15:0] OFS_RECT   = 16'h0004;
  localparam logic [15:0] OFS_POINT  = 16'h0008;
  localparam logic [15:0] OFS_COLOR  = 16'h000C;
  localparam logic [15:0] OFS_ACTION = 16'h0010;
  localparam logic [15:0] OFS_STATUS = 16'h0014;

  // The busy sample that brings the counter to TIMEOUT is the one that aborts.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    WR_RECT,
    WR_POINT,
    WR_COLOR,
    WR_ACTION,
    WAIT_DONE
  } state_t;

  state_t state;

  logic [73:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [73:0]   head;

  logic [1:0]    op_q;
  logic [31:0]   rect_q;
  logic [15:0]   point_q;
  logic [23:0]   color_q;
  logic [15:0]   tcnt;

  logic          gpu_busy;
  logic          unused_rdata;

  assign gpu_busy     = gpu_rdata[0];
  assign unused_rdata = ^gpu_rdata[31:1];

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign busy      = !empty || (state != IDLE);

  function automatic logic [31:0] reg_addr(input logic [15:0] ofs);
    return {GPU_BASE[31:16], ofs};
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_rect, cmd_point, cmd_color};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // GPU outputs are registered from the next state, so each bus access is
  // presented for exactly the cycle the FSM spends in the matching state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_q        <= '0;
      rect_q      <= '0;
      point_q     <= '0;
      color_q     <= '0;
      tcnt        <= '0;
      cmd_count   <= '0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
      gpu_enable  <= 1'b0;
      gpu_data    <= '0;
      gpu_address <= reg_addr(OFS_STATUS);
    end else begin
      gpu_enable  <= 1'b0;
      gpu_data    <= '0;
      gpu_address <= reg_addr(OFS_STATUS);

      if (err_clr) begin
        err_op      <= 1'b0;
        err_timeout <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!empty) begin
            if (head[73:72] == 2'd3) begin
              err_op <= 1'b1;
            end else begin
              op_q    <= head[73:72];
              rect_q  <= head[71:40];
              point_q <= head[39:24];
              color_q <= head[23:0];
              tcnt    <= '0;
              state   <= POLL;
            end
          end
        end

        POLL: begin
          if (!gpu_busy) begin
            gpu_enable <= 1'b1;
            case (op_q)
              2'd2: begin
                state       <= WR_RECT;
                gpu_address <= reg_addr(OFS_RECT);
                gpu_data    <= rect_q;
              end
              2'd1: begin
                state       <= WR_POINT;
                gpu_address <= reg_addr(OFS_POINT);
                gpu_data    <= {16'b0, point_q};
              end
              default: begin
                state       <= WR_COLOR;
                gpu_address <= reg_addr(OFS_COLOR);
                gpu_data    <= {8'b0, color_q};
              end
            endcase
          end else if (tcnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end

        WR_RECT, WR_POINT: begin
          state       <= WR_COLOR;
          gpu_enable  <= 1'b1;
          gpu_address <= reg_addr(OFS_COLOR);
          gpu_data    <= {8'b0, color_q};
        end

        WR_COLOR: begin
          state       <= WR_ACTION;
          gpu_enable  <= 1'b1;
          gpu_address <= reg_addr(OFS_ACTION);
          gpu_data    <= {30'b0, op_q};
        end

        WR_ACTION: begin
          state <= WAIT_DONE;
          tcnt  <= '0;
        end

        WAIT_DONE: begin
          if (!gpu_busy) begin
            cmd_count <= cmd_count + 16'd1;
            state     <= IDLE;
          end else if (tcnt == TIMEOUT_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_cmd_master.sv
// tb_gpu_cmd_master: directed bench for gpu_cmd_master with a behavioral GPU
// that stays busy for a fixed number of cycles after each action write.
module tb_gpu_cmd_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_rect = 32'd0;
  logic [15:0] cmd_point = 16'd0;
  logic [23:0] cmd_color = 24'd0;
  logic        gpu_enable;
  logic [31:0] gpu_address;
  logic [31:0] gpu_data;
  logic [31:0] gpu_rdata;
  logic        busy;
  logic [15:0] cmd_count;
  logic        err_op;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          draw_cnt = 0;
  logic        stuck = 1'b0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          ws_q[$];

  logic [31:0] exp_a[13];
  logic [31:0] exp_d[13];

  gpu_cmd_master #(
    .FIFO_DEPTH(4),
    .GPU_BASE(32'hABCD_0000),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_rect(cmd_rect),
    .cmd_point(cmd_point),
    .cmd_color(cmd_color),
    .gpu_enable(gpu_enable),
    .gpu_address(gpu_address),
    .gpu_data(gpu_data),
    .gpu_rdata(gpu_rdata),
    .busy(busy),
    .cmd_count(cmd_count),
    .err_op(err_op),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Each write is stamped with the index of the edge that captures it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gpu_enable) begin
      wa_q.push_back(gpu_address);
      wd_q.push_back(gpu_data);
      ws_q.push_back(cyc);
    end
    if (gpu_enable && gpu_address[15:0] == 16'h0010) draw_cnt <= 12;
    else if (draw_cnt != 0) draw_cnt <= draw_cnt - 1;
  end

  assign gpu_rdata = (gpu_address[15:0] == 16'h0014) ?
                     {31'd0, (draw_cnt != 0) || stuck} : 32'd0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int k);
    while (cyc <= k) @(negedge clk);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    ws_q.delete();
  endtask

  // Called at a negedge; leaves cmd_valid high so calls can run back to back.
  task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] rect,
                                input logic [15:0] point, input logic [23:0] color);
    int budget = 50;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rect  = rect;
    cmd_point = point;
    cmd_color = color;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check_output("push_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_count(input logic [15:0] target, input int budget);
    int b = budget;
    while (cmd_count != target && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_output("cmd_count_reach", 32'(cmd_count), 32'(target));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset values must appear without any clock edge.
    #1 reset_n = 1'b0;
    #2;
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_cmd_count", 32'(cmd_count), 32'd0);
    check_output("rst_err_op", 32'(err_op), 32'd0);
    check_output("rst_err_timeout", 32'(err_timeout), 32'd0);
    check_output("rst_gpu_enable", 32'(gpu_enable), 32'd0);
    check_output("rst_gpu_data", gpu_data, 32'd0);
    check_output("rst_gpu_address", gpu_address, 32'hABCD_0014);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("idle_busy", 32'(busy), 32'd0);

    // Single rectangle: writes on edges N+3..N+5, done on edge N+18.
    clear_log();
    n = cyc;
    apply_stimulus(2'd2, 32'h0205_0408, 16'h0000, 24'hFF0000);
    cmd_valid = 1'b0;
    wait_edge(n + 17);
    check_output("rect_busy_held", 32'(busy), 32'd1);
    check_output("rect_count_before", 32'(cmd_count), 32'd0);
    wait_edge(n + 18);
    check_output("rect_count_after", 32'(cmd_count), 32'd1);
    check_output("rect_busy_after", 32'(busy), 32'd0);
    check_output("rect_nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      check_output("rect_w0_addr", wa_q[0], 32'hABCD_0004);
      check_output("rect_w0_data", wd_q[0], 32'h0205_0408);
      check_output("rect_w0_edge", 32'(ws_q[0]), 32'(n + 3));
      check_output("rect_w1_addr", wa_q[1], 32'hABCD_000C);
      check_output("rect_w1_data", wd_q[1], 32'h00FF_0000);
      check_output("rect_w1_edge", 32'(ws_q[1]), 32'(n + 4));
      check_output("rect_w2_addr", wa_q[2], 32'hABCD_0010);
      check_output("rect_w2_data", wd_q[2], 32'h0000_0002);
      check_output("rect_w2_edge", 32'(ws_q[2]), 32'(n + 5));
    end

    // Five back-to-back pushes: the fifth fills the FIFO.
    clear_log();
    apply_stimulus(2'd1, 32'h0, 16'h1122, 24'h000001);
    apply_stimulus(2'd0, 32'h0, 16'h0000, 24'h000002);
    apply_stimulus(2'd2, 32'h0102_0304, 16'h0000, 24'h000003);
    apply_stimulus(2'd1, 32'h0, 16'h3344, 24'h000004);
    apply_stimulus(2'd0, 32'h0, 16'h0000, 24'h000005);
    cmd_valid = 1'b0;
    check_output("fifo_full_ready", 32'(cmd_ready), 32'd0);
    check_output("fifo_full_busy", 32'(busy), 32'd1);
    wait_count(16'd6, 400);
    check_output("burst_busy_after", 32'(busy), 32'd0);
    exp_a[0]  = 32'hABCD_0008; exp_d[0]  = 32'h0000_1122;
    exp_a[1]  = 32'hABCD_000C; exp_d[1]  = 32'h0000_0001;
    exp_a[2]  = 32'hABCD_0010; exp_d[2]  = 32'h0000_0001;
    exp_a[3]  = 32'hABCD_000C; exp_d[3]  = 32'h0000_0002;
    exp_a[4]  = 32'hABCD_0010; exp_d[4]  = 32'h0000_0000;
    exp_a[5]  = 32'hABCD_0004; exp_d[5]  = 32'h0102_0304;
    exp_a[6]  = 32'hABCD_000C; exp_d[6]  = 32'h0000_0003;
    exp_a[7]  = 32'hABCD_0010; exp_d[7]  = 32'h0000_0002;
    exp_a[8]  = 32'hABCD_0008; exp_d[8]  = 32'h0000_3344;
    exp_a[9]  = 32'hABCD_000C; exp_d[9]  = 32'h0000_0004;
    exp_a[10] = 32'hABCD_0010; exp_d[10] = 32'h0000_0001;
    exp_a[11] = 32'hABCD_000C; exp_d[11] = 32'h0000_0005;
    exp_a[12] = 32'hABCD_0010; exp_d[12] = 32'h0000_0000;
    check_output("burst_nwrites", 32'(wa_q.size()), 32'd13);
    for (int i = 0; i < 13 && i < wa_q.size(); i++) begin
      check_output($sformatf("burst_w%0d_addr", i), wa_q[i], exp_a[i]);
      check_output($sformatf("burst_w%0d_data", i), wd_q[i], exp_d[i]);
    end

    // Illegal op, with err_clr coincident on the discarding edge.
    clear_log();
    apply_stimulus(2'd3, 32'hDEAD_BEEF, 16'h5555, 24'hAAAAAA);
    cmd_valid = 1'b0;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_output("errop_set_wins", 32'(err_op), 32'd1);
    repeat (4) @(negedge clk);
    check_output("errop_no_writes", 32'(wa_q.size()), 32'd0);
    check_output("errop_count", 32'(cmd_count), 32'd6);
    check_output("errop_busy", 32'(busy), 32'd0);
    check_output("errop_sticky", 32'(err_op), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_output("errop_cleared", 32'(err_op), 32'd0);

    // Stuck GPU: the 16th busy sample (edge N+17) aborts the command.
    clear_log();
    stuck = 1'b1;
    n = cyc;
    apply_stimulus(2'd0, 32'h0, 16'h0000, 24'h00ABCD);
    cmd_valid = 1'b0;
    wait_edge(n + 16);
    check_output("tmo_not_yet", 32'(err_timeout), 32'd0);
    check_output("tmo_busy_before", 32'(busy), 32'd1);
    wait_edge(n + 17);
    check_output("tmo_flag", 32'(err_timeout), 32'd1);
    check_output("tmo_idle", 32'(busy), 32'd0);
    check_output("tmo_count", 32'(cmd_count), 32'd6);
    check_output("tmo_no_writes", 32'(wa_q.size()), 32'd0);
    stuck = 1'b0;
    apply_stimulus(2'd2, 32'h0A0B_0C0D, 16'h0000, 24'h123456);
    cmd_valid = 1'b0;
    wait_count(16'd7, 100);
    check_output("post_tmo_nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() == 3) begin
      check_output("post_tmo_w0", wd_q[0], 32'h0A0B_0C0D);
      check_output("post_tmo_w1", wd_q[1], 32'h0012_3456);
      check_output("post_tmo_w2_addr", wa_q[2], 32'hABCD_0010);
    end
    check_output("tmo_flag_sticky", 32'(err_timeout), 32'd1);

    // Reset in WAIT_DONE with two commands still queued.
    clear_log();
    n = cyc;
    apply_stimulus(2'd0, 32'h0, 16'h0000, 24'h000011);
    apply_stimulus(2'd0, 32'h0, 16'h0000, 24'h000022);
    apply_stimulus(2'd0, 32'h0, 16'h0000, 24'h000033);
    cmd_valid = 1'b0;
    wait_edge(n + 6);
    check_output("midrst_busy_before", 32'(busy), 32'd1);
    check_output("midrst_writes_before", 32'(wa_q.size()), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_output("midrst_gpu_enable", 32'(gpu_enable), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("midrst_count", 32'(cmd_count), 32'd0);
    check_output("midrst_err_timeout", 32'(err_timeout), 32'd0);
    check_output("midrst_address", gpu_address, 32'hABCD_0014);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    repeat (40) @(negedge clk);
    check_output("postrst_no_writes", 32'(wa_q.size()), 32'd0);
    check_output("postrst_busy", 32'(busy), 32'd0);
    check_output("postrst_count", 32'(cmd_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_cmd_master.md
# gpu_cmd_master

Hardware command initiator for the memory-mapped GPU peripheral. Accepts draw commands through a valid/ready port, buffers them in a small FIFO, and replays each one as a sequence of bus accesses to the GPU register map. Per command it polls the status register, writes the operand and action registers, then polls until the draw completes. Sits between a command source (CPU store path or DMA) and the GPU's `gpu_enable`/`input_address`/`input_data`/`data_out` port.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `GPU_BASE`, 32'h0000_0000: base address; bits [31:16] are placed on `gpu_address[31:16]`.
- `TIMEOUT`, 65535: maximum poll cycles before abort; 16-bit counter.
- `clk` in 1: clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 2: 0 = white background, 1 = point, 2 = rectangle, 3 = illegal.
- `cmd_rect` in 32: {y0[31:24], x0[23:16], y1[15:8], x1[7:0]}.
- `cmd_point` in 16: {y[15:8], x[7:0]}.
- `cmd_color` in 24: RGB888.
- `gpu_enable` out 1: write strobe to GPU.
- `gpu_address` out 32: {GPU_BASE[31:16], offset}.
- `gpu_data` out 32: write data.
- `gpu_rdata` in 32: GPU combinational read data; bit0 = busy when offset is 0x14.
- `busy` out 1: FIFO non-empty or FSM not in IDLE.
- `cmd_count` out 16: completed commands; wraps from 0xFFFF to 0.
- `err_op` out 1: sticky; an illegal op was discarded.
- `err_timeout` out 1: sticky; a poll timed out.
- `err_clr` in 1: clears both sticky flags; set wins if coincident.

## Operation
- FIFO:
  - 74-bit entries {op, rect, point, color}.
  - Push on `cmd_valid && cmd_ready`.
  - Pop only when FSM is in IDLE and the FIFO is non-empty; pop moves the entry into working registers.
  - When full, `cmd_ready`=0. Push and pop may occur in the same cycle.
- FSM states: IDLE, POLL, WR_RECT, WR_POINT, WR_COLOR, WR_ACTION, WAIT_DONE.
- IDLE:
  - Pop; illegal op (3) → set `err_op` and stay in IDLE; the entry is discarded and no GPU access occurs.
  - Legal op → POLL.
- POLL:
  - Drive offset 0x14 with `gpu_enable`=0 and sample `gpu_rdata[0]`.
  - 0 → first write state: op2 → WR_RECT; op1 → WR_POINT; op0 → WR_COLOR.
- Write states, one cycle each, `gpu_enable`=1:
  - WR_RECT: offset 0x4, data = rect → WR_COLOR.
  - WR_POINT: offset 0x8, data = {16'b0, point} → WR_COLOR.
  - WR_COLOR: offset 0xC, data = {8'b0, color} → WR_ACTION.
  - WR_ACTION: offset 0x10, data = {30'b0, op} → WAIT_DONE.
- WAIT_DONE:
  - Offset 0x14, `gpu_enable`=0.
  - `gpu_rdata[0]`=0 → `cmd_count`+1, → IDLE.
- Timeout:
  - The counter clears on entry to POLL and WAIT_DONE and increments each cycle busy reads 1.
  - Reaching TIMEOUT sets `err_timeout` and returns to IDLE; the command is not counted.
- In IDLE: `gpu_address` = {GPU_BASE[31:16], 16'h0014}, `gpu_data`=0, `gpu_enable`=0.

## Timing
- Reset values (applied immediately on `reset_n` low):
  - FSM IDLE, FIFO empty.
  - `cmd_ready`=1, `busy`=0, `cmd_count`=0, `err_op`=0, `err_timeout`=0.
  - `gpu_enable`=0, `gpu_data`=0, `gpu_address`={GPU_BASE[31:16],16'h0014}.
- All GPU-side outputs are registered.
- Push to first write, GPU idle: push edge N, pop N+1, POLL N+2, first write N+3.
- Writes occupy consecutive cycles:
  - op2: 3 writes (rect, color, action).
  - op1: 3 writes (point, color, action).
  - op0: 2 writes (color, action).
- The GPU status reads busy starting the cycle after the action write, so the first WAIT_DONE sample is valid.
- `cmd_count` increments on the edge ending the WAIT_DONE cycle that sees busy=0.
- `busy` falls the cycle after IDLE is re-entered with the FIFO empty.
- Reset mid-command: the in-flight command and FIFO contents are lost. The GPU may still be drawing; the next command's POLL absorbs this.

## Test plan
1. Reset → all outputs at reset values above; `cmd_ready`=1 with no stimulus.
2. op2, rect=32'h0205_0408, color=24'hFF0000, behavioral GPU model → three consecutive writes: 0x4=0x02050408, 0xC=0x00FF0000, 0x10=0x2. Busy holds 12 cycles, then `cmd_count`=1 and `busy`=0.
3. Five back-to-back pushes, FIFO_DEPTH=4, GPU drawing → `cmd_ready` drops at full, all accepted. Executed strictly in order; `cmd_count`=5.
4. op3 → no `gpu_enable` pulse, `err_op`=1, `cmd_count` unchanged; `err_clr` pulse → `err_op`=0.
5. GPU model stuck busy, TIMEOUT=16 → `err_timeout`=1 after 16 busy samples, FSM in IDLE. The next command proceeds normally once the model is released.
6. `reset_n` low during WAIT_DONE with 2 queued commands → `gpu_enable`=0 and `busy`=0 without a clock edge. No further writes after release.
